psi_stream_sched: RTL and testbench
===================================

// Module: psi_stream_sched
// PURPOSE
//  Sequential scheduler for the PSI bitwise-AND intersection datapath. Party bitmaps arrive
//  over one narrow W-bit valid/ready stream. The block time-multiplexes a single W-bit AND lane.
//  It accumulates the N-party intersection of B-bit sets and emits one B-bit result per set.
//  It sits between the party input FIFO and the result consumer.
// PARAMETERS
//  B  10  set size in bits (bitmap width), >=1
//  N  2   number of parties, >=2
//  W  5   lane width in bits per beat, 1..B; C = ceil(B/W) chunks per party
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  clr        in   1              synchronous flush: abort the current set
//  in_valid   in   1              input beat valid
//  in_ready   out  1              block accepts a beat
//  in_data    in   W              chunk of a party bitmap, LSB = lowest set index
//  exp_party  out  clog2(N)       party index expected for the next beat
//  exp_chunk  out  clog2(C)       chunk index expected for the next beat
//  out_valid  out  1              intersection result valid
//  out_ready  in   1              consumer accepts the result
//  out_data   out  B              intersection bitmap
//  out_card   out  clog2(B+1)     popcount of out_data (PSI_CARD_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=ACC, party/chunk counters=0, acc=0, in_ready=1, out_valid=0.
//  - Beat order is party-major. Party 0 sends chunks 0..C-1, then party 1, and so on to party N-1.
//  - States: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
//  - ACC, beat accepted (in_valid & in_ready):
//    - Party 0: acc[chunk c] <= in_data (load).
//    - Party >0: acc[chunk c] <= acc[chunk c] & in_data.
//    - Counter update: if c==C-1 then c<=0 and p<=p+1; otherwise c<=c+1.
//    - On the beat with p==N-1 and c==C-1: go to OUT, reset counters to 0.
//  - Last chunk: in_data bits at indices >= B are ignored; acc is exactly B bits.
//  - Latency: out_valid rises in the cycle after the final beat is accepted.
//  - Throughput: 1 beat/cycle. A set takes N*C beats, plus >=1 cycle in OUT.
//  - OUT: out_data=acc, held stable while out_valid=1 & out_ready=0.
//    - On out_ready=1: go to ACC; in_ready rises the next cycle.
//    - No bypass: input is never accepted in the same cycle as a result handshake.
//  - clr=1 in any state: next cycle state=ACC, counters=0, out_valid=0.
//    - A result pending in OUT is dropped.
//    - clr has priority over a simultaneous input beat or output handshake.
//  - exp_party/exp_chunk reflect the counters; they are 0 in OUT.
//  - in_valid without in_ready, and out_ready without out_valid, have no effect.
// CONFIGURATION
//  PSI_CARD_EN defined:
//    - out_card = popcount(acc), valid whenever out_valid=1.
//    - Combinational from the registered acc; zero added latency.
//  PSI_CARD_EN undefined: out_card port absent; no popcount logic is built.
// STRUCTURE
//  - Package psi_pkg: typedef psi_state_e {ACC, OUT}; function psi_chunks(B,W) returning ceil(B/W).
//  - Sub-module psi_popcount #(B): adder-tree popcount, instantiated only under PSI_CARD_EN.
//  - Top holds the FSM, the p/c counters, the acc register and the chunk-select AND lane.
// TESTING (B=10, N=2, W=5 unless noted)
//  - Basic set: beats 0x0E,0x16 (p0 = 0x2CE), then 0x15,0x0F (p1 = 0x1F5).
//    -> out_valid 1 cycle after the 4th beat; out_data=0x0C4; out_card=3.
//  - Backpressure: hold out_ready=0 for 5 cycles -> in_ready=0, out_data stable at 0x0C4;
//    out_ready=1 -> in_ready=1 on the next cycle.
//  - Input bubbles: in_valid toggled randomly -> exp_party/exp_chunk advance only on accepted beats;
//    result still 0x0C4.
//  - Flush: clr after 3 beats, then a full set with all beats 0x1F
//    -> out_data=0x3FF, out_card=10; no residue from the aborted set.
//  - Padding: W=4 (C=3), p0 all chunks 0xF, p1 chunk2=0xF -> out_data=0x3FF; bits >=10 ignored.
//  - Reset mid-set: rst_n low after 2 beats -> in_ready=1, out_valid=0 immediately;
//    counters=0; the next full set computes correctly.

Source files
------------

// File: rtl/psi_pkg.sv
// Shared types and sizing helpers for the PSI intersection scheduler.
package psi_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } psi_state_e;

    // Number of W-bit chunks needed to carry a B-bit bitmap.
    function automatic int unsigned psi_chunks(input int unsigned b, input int unsigned w);
        return (b + w - 1) / w;
    endfunction

    // Index width that stays at least one bit wide when only one value exists.
    function automatic int unsigned psi_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psi_popcount.sv
// Adder-tree population count of a B-bit vector; built only when PSI_CARD_EN is defined.
module psi_popcount #(
    parameter int unsigned B    = 10,
    parameter int unsigned CntW = $clog2(B + 1)
) (
    input  logic [B-1:0]    data_i,
    output logic [CntW-1:0] cnt_o
);

    localparam int unsigned Leaves = (B > 1) ? (1 << $clog2(B)) : 1;

    // Heap-ordered tree: node k sums nodes 2k and 2k+1, leaves start at index Leaves.
    logic [CntW-1:0] tree [2*Leaves];

    always_comb begin
        for (int unsigned k = 0; k < 2 * Leaves; k++) begin
            tree[k] = '0;
        end
        for (int unsigned i = 0; i < B; i++) begin
            tree[Leaves + i] = CntW'(data_i[i]);
        end
        for (int unsigned k = Leaves - 1; k >= 1; k--) begin
            tree[k] = tree[2*k] + tree[2*k + 1];
        end
        cnt_o = tree[1];
    end

endmodule

// File: rtl/psi_stream_sched.sv
// Time-multiplexed N-party bitwise-AND intersection over a W-bit valid/ready stream.
// Optional popcount output is enabled with the PSI_CARD_EN macro.
module psi_stream_sched
    import psi_pkg::*;
#(
    parameter int unsigned B    = 10,
    parameter int unsigned N    = 2,
    parameter int unsigned W    = 5,
    localparam int unsigned C    = psi_chunks(B, W),
    localparam int unsigned PW   = psi_idx_w(N),
    localparam int unsigned CW   = psi_idx_w(C),
    localparam int unsigned CntW = $clog2(B + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic [PW-1:0]   exp_party,
    output logic [CW-1:0]   exp_chunk,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef PSI_CARD_EN
    output logic [CntW-1:0] out_card,
`endif
    output logic [B-1:0]    out_data
);

    localparam logic [CW-1:0] LastChunk = CW'(C - 1);
    localparam logic [PW-1:0] LastParty = PW'(N - 1);

    psi_state_e      state_q, state_d;
    logic [PW-1:0]   party_q, party_d;
    logic [CW-1:0]   chunk_q, chunk_d;
    logic [B-1:0]    acc_q, acc_d;
    logic [B-1:0]    acc_lane;

    // Chunk-select AND lane; input bits beyond B on the last chunk have no target.
    always_comb begin
        acc_lane = acc_q;
        for (int unsigned i = 0; i < B; i++) begin
            if ((i / W) == 32'(chunk_q)) begin
                if (party_q == '0) begin
                    acc_lane[i] = in_data[i % W];
                end else begin
                    acc_lane[i] = acc_q[i] & in_data[i % W];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        party_d = party_q;
        chunk_d = chunk_q;
        acc_d   = acc_q;

        if (clr) begin
            state_d = ACC;
            party_d = '0;
            chunk_d = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (in_valid) begin
                        acc_d = acc_lane;
                        if (chunk_q == LastChunk) begin
                            chunk_d = '0;
                            if (party_q == LastParty) begin
                                party_d = '0;
                                state_d = OUT;
                            end else begin
                                party_d = party_q + 1'b1;
                            end
                        end else begin
                            chunk_d = chunk_q + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_d = ACC;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            party_q <= '0;
            chunk_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            party_q <= party_d;
            chunk_q <= chunk_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign out_data  = acc_q;
    assign exp_party = party_q;
    assign exp_chunk = chunk_q;

`ifdef PSI_CARD_EN
    psi_popcount #(
        .B    (B),
        .CntW (CntW)
    ) u_popcount (
        .data_i (acc_q),
        .cnt_o  (out_card)
    );
`endif

endmodule

// File: tb/tb_psi_stream_sched.sv
// Directed self-checking bench for psi_stream_sched (B=10, N=2, W=5, plus a W=4 padding instance).
module tb_psi_stream_sched;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [4:0] in_data;
    logic [0:0] exp_party, exp_chunk;
    logic [9:0] out_data;
    logic [3:0] out_card;

    logic       p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [3:0] p_in_data;
    logic [0:0] p_exp_party;
    logic [1:0] p_exp_chunk;
    logic [9:0] p_out_data;
    logic [3:0] p_out_card;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    psi_stream_sched #(.B(10), .N(2), .W(5)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .exp_party (exp_party),
        .exp_chunk (exp_chunk),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PSI_CARD_EN
        .out_card  (out_card),
`endif
        .out_data  (out_data)
    );

    psi_stream_sched #(.B(10), .N(2), .W(4)) u_pad (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (p_in_valid),
        .in_ready  (p_in_ready),
        .in_data   (p_in_data),
        .exp_party (p_exp_party),
        .exp_chunk (p_exp_chunk),
        .out_valid (p_out_valid),
        .out_ready (p_out_ready),
`ifdef PSI_CARD_EN
        .out_card  (p_out_card),
`endif
        .out_data  (p_out_data)
    );

`ifndef PSI_CARD_EN
    assign out_card   = '0;
    assign p_out_card = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pbeat(input logic [3:0] d);
        p_in_valid = 1'b1;
        p_in_data  = d;
        step();
        p_in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int guard;
        logic [4:0] bub_data [4];
        bub_data[0] = 5'h0E; bub_data[1] = 5'h16; bub_data[2] = 5'h15; bub_data[3] = 5'h0F;

        rst_n = 1'b0; clr = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_party", exp_party, 0);
        chk("rst_chunk", exp_chunk, 0);
        chk("rst_acc", out_data, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Basic set
        beat(5'h0E);
        chk("basic_c1", {exp_party, exp_chunk}, 2'b01);
        beat(5'h16);
        chk("basic_p1", {exp_party, exp_chunk}, 2'b10);
        beat(5'h15);
        chk("basic_out_early", out_valid, 0);
        beat(5'h0F);
        chk("basic_out_valid", out_valid, 1);
        chk("basic_in_ready", in_ready, 0);
        chk("basic_data", out_data, 10'h0C4);
        chk("basic_exp", {exp_party, exp_chunk}, 2'b00);
`ifdef PSI_CARD_EN
        chk("basic_card", out_card, 3);
`endif

        // Backpressure, with an ignored input beat offered meanwhile
        in_valid = 1'b1; in_data = 5'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_data", out_data, 10'h0C4);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_no_bypass", {exp_party, exp_chunk}, 2'b00);

        // Input bubbles
        k = 0;
        guard = 0;
        while (k < 4 && guard < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = bub_data[k];
            chk("bub_party", exp_party, k / 2);
            chk("bub_chunk", exp_chunk, k % 2);
            step();
            if (in_valid) k++;
            guard++;
        end
        in_valid = 1'b0;
        chk("bub_done", k, 4);
        chk("bub_valid", out_valid, 1);
        chk("bub_data", out_data, 10'h0C4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush after 3 zero beats, then an all-ones set
        beat(5'h00); beat(5'h00); beat(5'h00);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("flush_exp", {exp_party, exp_chunk}, 2'b00);
        chk("flush_valid", out_valid, 0);
        repeat (4) beat(5'h1F);
        chk("flush_set_valid", out_valid, 1);
        chk("flush_set_data", out_data, 10'h3FF);
`ifdef PSI_CARD_EN
        chk("flush_set_card", out_card, 10);
`endif
        // clr in OUT drops the result and wins over out_ready
        clr = 1'b1; out_ready = 1'b1;
        step();
        clr = 1'b0; out_ready = 1'b0;
        chk("drop_valid", out_valid, 0);
        chk("drop_ready", in_ready, 1);
        // clr wins over a simultaneous beat
        clr = 1'b1; in_valid = 1'b1; in_data = 5'h1F;
        step();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_prio", {exp_party, exp_chunk}, 2'b00);

        // Reset mid-set
        beat(5'h00); beat(5'h00);
        chk("mid_pre", exp_party, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_exp", {exp_party, exp_chunk}, 2'b00);
        step();
        rst_n = 1'b1;
        step();
        beat(5'h0E); beat(5'h16); beat(5'h15); beat(5'h0F);
        chk("mid_set_valid", out_valid, 1);
        chk("mid_set_data", out_data, 10'h0C4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Padding instance: W=4, C=3
        pbeat(4'hF); pbeat(4'hF);
        chk("pad_c2", p_exp_chunk, 2);
        pbeat(4'hF);
        chk("pad_p1", {p_exp_party, p_exp_chunk}, 3'b100);
        pbeat(4'hF); pbeat(4'hF); pbeat(4'hF);
        chk("pad_valid", p_out_valid, 1);
        chk("pad_data", p_out_data, 10'h3FF);
`ifdef PSI_CARD_EN
        chk("pad_card", p_out_card, 10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
